uart_rx_param: RTL and testbench

Parametrised successor of the fixed 9600-baud RS-232 receiver. Deserialises asynchronous 8N1-style frames with configurable data width, parity and stop bits, applies a configurable additive offset, and presents a start/stop-framed word to the transmitter via a rdy/confirm handshake. Adds input synchronisation, false-start rejection, parity/framing error flags and overrun detection.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_param.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver/transmitter family: parity
// selectors, receiver FSM encoding and the default bit period.
package uart_pkg;

    // Parity selector values for the PARITY parameter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Default bit period: 100 MHz system clock, 9600 baud, rounded to nearest
    localparam int CLK_HZ_DEFAULT       = 100_000_000;
    localparam int BAUD_DEFAULT         = 9600;
    localparam int CLKS_PER_BIT_DEFAULT = (CLK_HZ_DEFAULT + BAUD_DEFAULT / 2) / BAUD_DEFAULT;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; i_clear forces it
// back to 0. o_half fires at HALF-1 (mid start bit), o_full at the last count.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_half,
    output logic o_full
);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign o_half = (r_cnt == CNT_W'(HALF - 1));
    assign o_full = w_wrap;

    // Free-running bit timer, cleared on request or at end of a bit period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised asynchronous serial receiver. Samples a synchronised line at
// mid-bit, checks parity and stop bits, adds a fixed offset to the payload and
// presents a {1, payload, 0} word to the transmitter under a rdy/confirm
// handshake. Frames completing while a word is still unconfirmed are dropped
// and flagged through the sticky ovr output.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1,
    parameter int ADD_OFFSET   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RXr,
    output logic [DATA_BITS+1:0] TXr,
    output logic                 rdy,
    input  logic                 confirm,
    output logic                 par_err,
    output logic                 frm_err,
    output logic                 ovr
);
    localparam int                   IDX_W     = $clog2(DATA_BITS);
    localparam logic                 PARITY_ON = (PARITY == PARITY_EVEN) || (PARITY == PARITY_ODD);
    localparam logic                 ODD_SENSE = (PARITY == PARITY_ODD);
    localparam logic [DATA_BITS-1:0] OFFSET    = DATA_BITS'(ADD_OFFSET);

    // Input synchroniser; idle line is high so the flops reset to 1
    logic [1:0]           r_sync;
    logic                 w_rx_s;

    // FSM
    rx_state_t            r_state;
    rx_state_t            w_state_next;

    // Bit timer
    logic                 w_half;
    logic                 w_full;

    // Per-state strobes
    logic                 w_timer_clr;
    logic                 w_start_ok;
    logic                 w_data_smp;
    logic                 w_par_smp;
    logic                 w_stop_smp;
    logic                 w_done;

    // Frame datapath
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_stop_cnt;
    logic                 r_par_bad;
    logic                 r_frm_bad;
    logic                 w_last_bit;
    logic                 w_last_stop;

    // Presented word and handshake
    logic [DATA_BITS-1:0] r_tx_data;
    logic                 r_rdy;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 r_ovr;
    logic                 w_accept;

    assign w_rx_s      = r_sync[1];
    assign w_last_bit  = (r_idx == IDX_W'(DATA_BITS - 1));
    assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
    assign w_accept    = !r_rdy || confirm;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .i_clear(w_timer_clr),
        .o_half (w_half),
        .o_full (w_full)
    );

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RXr};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) w_state_next = ST_START;
            end
            ST_START: begin
                // A line that is high again at mid start bit was a glitch
                if (w_half) w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_full && w_last_bit) w_state_next = PARITY_ON ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_full) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                // All stop bits are sampled even after a low one
                if (w_full && w_last_stop) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM output strobes
    always_comb begin
        w_timer_clr = 1'b0;
        w_start_ok  = 1'b0;
        w_data_smp  = 1'b0;
        w_par_smp   = 1'b0;
        w_stop_smp  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE:   w_timer_clr = 1'b1;
            ST_START: begin
                w_timer_clr = w_half;
                w_start_ok  = w_half && !w_rx_s;
            end
            ST_DATA:   w_data_smp  = w_full;
            ST_PARITY: w_par_smp   = w_full;
            ST_STOP:   w_stop_smp  = w_full;
            ST_DONE: begin
                w_done      = 1'b1;
                w_timer_clr = 1'b1;
            end
            default:   w_timer_clr = 1'b1;
        endcase
    end

    // Frame datapath: LSB-first shift-in, bit index, parity and stop checks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift    <= '1;
            r_idx      <= '0;
            r_stop_cnt <= 1'b0;
            r_par_bad  <= 1'b0;
            r_frm_bad  <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_idx      <= '0;
                r_stop_cnt <= 1'b0;
                r_par_bad  <= 1'b0;
                r_frm_bad  <= 1'b0;
            end
            if (w_data_smp) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                r_idx   <= r_idx + 1'b1;
            end
            if (w_par_smp) begin
                // Even parity: data^bit must be 0; odd parity: must be 1
                r_par_bad <= (((^r_shift) ^ w_rx_s) != ODD_SENSE);
            end
            if (w_stop_smp) begin
                if (!w_rx_s) r_frm_bad <= 1'b1;
                r_stop_cnt <= r_stop_cnt + 1'b1;
            end
        end
    end

    // Output word and handshake: load on DONE if free, otherwise flag overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_data <= '1;
            r_rdy     <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovr     <= 1'b0;
        end else if (w_done) begin
            if (w_accept) begin
                r_tx_data <= r_shift + OFFSET;
                r_par_err <= r_par_bad;
                r_frm_err <= r_frm_bad;
                r_rdy     <= 1'b1;
                // Old word confirmed in the same cycle the new one lands
                if (r_rdy) r_ovr <= 1'b0;
            end else begin
                r_ovr <= 1'b1;
            end
        end else if (confirm && r_rdy) begin
            r_rdy <= 1'b0;
            r_ovr <= 1'b0;
        end
    end

    assign TXr     = {1'b1, r_tx_data, 1'b0};
    assign rdy     = r_rdy;
    assign par_err = r_par_err;
    assign frm_err = r_frm_err;
    assign ovr     = r_ovr;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1 default, 7-bit even parity
// with two stop bits, 9-bit odd parity) driven with directed and random
// frames and compared against a frame-level reference model.
module tb_uart_rx_param;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    localparam int DB0 = 8, PAR0 = 0, SB0 = 1, OFF0 = 32;
    localparam int DB1 = 7, PAR1 = 1, SB1 = 2, OFF1 = 100;
    localparam int DB2 = 9, PAR2 = 2, SB2 = 1, OFF2 = 500;

    logic clk = 1'b0;
    logic rst;
    logic rx_line [3];
    logic conf_in [3];
    logic rdy_o   [3];
    logic par_o   [3];
    logic frm_o   [3];
    logic ovr_o   [3];
    logic [DB0+1:0] tx0;
    logic [DB1+1:0] tx1;
    logic [DB2+1:0] tx2;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state per instance
    int e_rdy [3];
    int e_tx  [3];
    int e_par [3];
    int e_frm [3];
    int e_ovr [3];

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB0), .PARITY(PAR0), .STOP_BITS(SB0), .ADD_OFFSET(OFF0)) u_dut0 (
        .clk(clk), .rst(rst), .RXr(rx_line[0]), .TXr(tx0), .rdy(rdy_o[0]), .confirm(conf_in[0]),
        .par_err(par_o[0]), .frm_err(frm_o[0]), .ovr(ovr_o[0]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB1), .PARITY(PAR1), .STOP_BITS(SB1), .ADD_OFFSET(OFF1)) u_dut1 (
        .clk(clk), .rst(rst), .RXr(rx_line[1]), .TXr(tx1), .rdy(rdy_o[1]), .confirm(conf_in[1]),
        .par_err(par_o[1]), .frm_err(frm_o[1]), .ovr(ovr_o[1]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB2), .PARITY(PAR2), .STOP_BITS(SB2), .ADD_OFFSET(OFF2)) u_dut2 (
        .clk(clk), .rst(rst), .RXr(rx_line[2]), .TXr(tx2), .rdy(rdy_o[2]), .confirm(conf_in[2]),
        .par_err(par_o[2]), .frm_err(frm_o[2]), .ovr(ovr_o[2]));

    function automatic int p_db(input int s);
        return (s == 0) ? DB0 : (s == 1) ? DB1 : DB2;
    endfunction

    function automatic int p_par(input int s);
        return (s == 0) ? PAR0 : (s == 1) ? PAR1 : PAR2;
    endfunction

    function automatic int p_sb(input int s);
        return (s == 0) ? SB0 : (s == 1) ? SB1 : SB2;
    endfunction

    function automatic int p_off(input int s);
        return (s == 0) ? OFF0 : (s == 1) ? OFF1 : OFF2;
    endfunction

    // Framed word {1, value mod 2^db, 0} as an integer
    function automatic int tx_word(input int s, input int value);
        int db;
        db = p_db(s);
        return (1 << (db + 1)) + ((value % (1 << db)) * 2);
    endfunction

    // Line bits per frame including start
    function automatic int nbits(input int s);
        return 1 + p_db(s) + ((p_par(s) != 0) ? 1 : 0) + p_sb(s);
    endfunction

    // Drive-index (in clk periods from the start edge) of the DONE cycle:
    // 2 sync stages + IDLE detect, half a bit to mid start, then one full
    // period per remaining bit.
    function automatic int done_idx(input int s);
        return 3 + HALF + CPB * (nbits(s) - 1);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input int s, input string tag);
        int t;
        case (s)
            0:       t = int'(tx0);
            1:       t = int'(tx1);
            default: t = int'(tx2);
        endcase
        chk($sformatf("%s/u%0d/TXr", tag, s), t, e_tx[s]);
        chk($sformatf("%s/u%0d/rdy", tag, s), int'(rdy_o[s]), e_rdy[s]);
        chk($sformatf("%s/u%0d/par_err", tag, s), int'(par_o[s]), e_par[s]);
        chk($sformatf("%s/u%0d/frm_err", tag, s), int'(frm_o[s]), e_frm[s]);
        chk($sformatf("%s/u%0d/ovr", tag, s), int'(ovr_o[s]), e_ovr[s]);
        $display("frame %s u%0d: TXr=%0h rdy=%0d par=%0d frm=%0d ovr=%0d", tag, s, t,
                 rdy_o[s], par_o[s], frm_o[s], ovr_o[s]);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            e_rdy[s] = 0;
            e_tx[s]  = tx_word(s, (1 << p_db(s)) - 1);
            e_par[s] = 0;
            e_frm[s] = 0;
            e_ovr[s] = 0;
        end
    endtask

    // Frame-level behaviour: parity/stop evaluation and the handshake rule
    task automatic model_frame(input int s, input int data, input int pbit, input int stop_mask, input int conf_done);
        int ones;
        int pe;
        int fe;
        ones = $countones(data) + pbit;
        pe = 0;
        fe = 0;
        if (p_par(s) == 1) pe = ones % 2;
        else if (p_par(s) == 2) pe = ((ones % 2) == 0) ? 1 : 0;
        for (int i = 0; i < p_sb(s); i++) begin
            if (((stop_mask >> i) & 1) == 0) fe = 1;
        end
        if (e_rdy[s] == 0 || conf_done != 0) begin
            e_tx[s]  = tx_word(s, data + p_off(s));
            e_par[s] = pe;
            e_frm[s] = fe;
            if (e_rdy[s] != 0) e_ovr[s] = 0;
            e_rdy[s] = 1;
        end else begin
            e_ovr[s] = 1;
        end
    endtask

    // Serialise one frame; optionally pulse confirm at drive index conf_at,
    // or assert reset at drive index rst_at and abandon the frame.
    task automatic send_frame(input int s, input int data, input int pbit, input int stop_mask,
                              input int conf_at, input int rst_at);
        int nb;
        int db;
        int pon;
        int b;
        logic v;
        nb  = nbits(s);
        db  = p_db(s);
        pon = (p_par(s) != 0) ? 1 : 0;
        for (int j = 0; j < nb * CPB; j++) begin
            @(negedge clk);
            b = j / CPB;
            if (b == 0) v = 1'b0;
            else if (b <= db) v = data[b-1];
            else if (pon == 1 && b == db + 1) v = pbit[0];
            else v = stop_mask[b-db-1-pon];
            rx_line[s] = v;
            conf_in[s] = (j == conf_at);
            if (j == rst_at) begin
                rst        = 1'b0;
                rx_line[s] = 1'b1;
                conf_in[s] = 1'b0;
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                rx_line[s] = 1'b1;
                conf_in[s] = 1'b0;
            end
        end
    endtask

    task automatic confirm_pulse(input int s);
        @(negedge clk);
        rx_line[s] = 1'b1;
        conf_in[s] = 1'b1;
        @(negedge clk);
        conf_in[s] = 1'b0;
        if (e_rdy[s] != 0) begin
            e_rdy[s] = 0;
            e_ovr[s] = 0;
        end
    endtask

    initial begin
        int s;
        int data;
        int pbit;
        int smask;
        int conf_at;

        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_line[i] = 1'b1;
            conf_in[i] = 1'b0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_all(i, "reset");
        rst = 1'b1;
        idle(5);

        // 0x41 on the default instance, then confirm
        send_frame(0, 'h41, 0, 1, -1, -1);
        model_frame(0, 'h41, 0, 1, 0);
        check_all(0, "rx41");
        confirm_pulse(0);
        check_all(0, "rx41_conf");

        // Offset wrap: 0xF0 + 32 -> 0x10
        send_frame(0, 'hF0, 0, 1, -1, -1);
        model_frame(0, 'hF0, 0, 1, 0);
        check_all(0, "rxF0");
        confirm_pulse(0);
        idle(4);

        // Three-clock low glitch on idle line must be rejected
        @(negedge clk);
        rx_line[0] = 1'b0;
        repeat (2) @(negedge clk);
        idle(200);
        check_all(0, "glitch");

        // Even parity instance: bad parity, good parity, low second stop bit
        send_frame(1, 'h03, 1, 3, -1, -1);
        model_frame(1, 'h03, 1, 3, 0);
        check_all(1, "par_bad");
        confirm_pulse(1);
        send_frame(1, 'h03, 0, 3, -1, -1);
        model_frame(1, 'h03, 0, 3, 0);
        check_all(1, "par_ok");
        confirm_pulse(1);
        send_frame(1, 'h03, 0, 1, -1, -1);
        model_frame(1, 'h03, 0, 1, 0);
        check_all(1, "frm_bad");
        confirm_pulse(1);
        idle(20);

        // Back-to-back without confirm -> overrun, word held
        send_frame(0, 'h41, 0, 1, -1, -1);
        model_frame(0, 'h41, 0, 1, 0);
        send_frame(0, 'h42, 0, 1, -1, -1);
        model_frame(0, 'h42, 0, 1, 0);
        check_all(0, "ovr");
        confirm_pulse(0);
        check_all(0, "ovr_conf");
        idle(4);

        // Back-to-back with confirm landing in the DONE cycle
        send_frame(0, 'h41, 0, 1, -1, -1);
        model_frame(0, 'h41, 0, 1, 0);
        send_frame(0, 'h42, 0, 1, done_idx(0), -1);
        model_frame(0, 'h42, 0, 1, 1);
        check_all(0, "conf_in_done");

        // Reset in the middle of data bit 4 while a word is pending
        send_frame(0, 'h99, 0, 1, -1, 4 * CPB + HALF);
        #1;
        model_reset();
        check_all(0, "mid_reset");
        @(negedge clk);
        rst = 1'b1;
        idle(5);
        send_frame(0, 'h55, 0, 1, -1, -1);
        model_frame(0, 'h55, 0, 1, 0);
        check_all(0, "rx55");
        confirm_pulse(0);
        idle(12);

        // Random frames across all instances
        for (int k = 0; k < 18; k++) begin
            s     = k % 3;
            data  = int'($urandom_range(0, (1 << p_db(s)) - 1));
            pbit  = int'($urandom_range(0, 1));
            smask = (1 << p_sb(s)) - 1;
            if ($urandom_range(0, 3) == 0) smask = smask & ~(1 << $urandom_range(0, p_sb(s) - 1));
            conf_at = ($urandom_range(0, 3) == 0) ? done_idx(s) : -1;
            send_frame(s, data, pbit, smask, conf_at, -1);
            model_frame(s, data, pbit, smask, (conf_at >= 0) ? 1 : 0);
            check_all(s, $sformatf("rand%0d", k));
            if ($urandom_range(0, 2) != 0) begin
                confirm_pulse(s);
                check_all(s, $sformatf("rand%0d_conf", k));
            end
            idle(int'($urandom_range(12, 24)));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
